// File: rtl/display7_pkg.sv
// Shared constants for the 7-segment display path: the active-low glyph table,
// the all-off pattern and the segment bit positions (bit 0 = a ... bit 6 = g).
package display7_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low glyphs; element [n] is the pattern for hex digit n.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [SEG_W-1:0] SEG_ALL_OFF = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational hex-digit to segment lookup; polarity is applied per
// segment so the same table serves common-anode and common-cathode displays.
module seg7_decode
    import display7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0]       digit,
    output logic [SEG_W-1:0] seg
);

    localparam logic INVERT = ~ACTIVE_LOW;

    logic [SEG_W-1:0] glyph;

    assign glyph = SEG_TABLE[digit];

    generate
        for (genvar gi = 0; gi < SEG_W; gi++) begin : g_seg
            assign seg[gi] = glyph[gi] ^ INVERT;
        end
    endgenerate

endmodule

// File: rtl/display7.sv
// Registered 7-segment driver: one-cycle latency from iData to oData, with a
// synchronous reset that blanks the display in either polarity.
module display7
    import display7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [3:0]       iData,
    output logic [SEG_W-1:0] oData
);

    localparam logic [SEG_W-1:0] BLANK = ACTIVE_LOW ? SEG_ALL_OFF : ~SEG_ALL_OFF;

    logic [SEG_W-1:0] seg_next;
    logic [SEG_W-1:0] seg_reg;

    seg7_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .digit(iData),
        .seg  (seg_next)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            seg_reg <= BLANK;
        end else begin
            seg_reg <= seg_next;
        end
    end

    assign oData = seg_reg;

endmodule

// File: tb/tb_display7.sv
// Scoreboard bench for display7: both polarities are driven from the same
// stimulus; expected patterns are queued at each edge and checked mid-cycle.
module tb_display7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = 4'h0;
    logic [6:0] out_lo;
    logic [6:0] out_hi;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] digit;
        logic [6:0] exp_lo;
        logic [6:0] exp_hi;
    } exp_t;

    exp_t sb[$];

    // Reference glyphs, active-low, g..a, written out from the digit table.
    logic [6:0] ref_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    display7 #(.ACTIVE_LOW(1'b1)) dut_lo (
        .iClk (clk),
        .iRst (rst),
        .iData(data),
        .oData(out_lo)
    );

    display7 #(.ACTIVE_LOW(1'b0)) dut_hi (
        .iClk (clk),
        .iRst (rst),
        .iData(data),
        .oData(out_hi)
    );

    // Drive one cycle of inputs, then queue what the registers must show.
    task automatic step(input logic r, input logic [3:0] d);
        exp_t e;
        rst  = r;
        data = d;
        @(posedge clk);
        e.rst    = r;
        e.digit  = d;
        e.exp_lo = r ? 7'b1111111 : ref_tbl[d];
        e.exp_hi = r ? 7'b0000000 : ~ref_tbl[d];
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (out_lo !== e.exp_lo) begin
                fails++;
                $display("FAIL lo rst=%0b digit=%h got=%b exp=%b", e.rst, e.digit, out_lo, e.exp_lo);
            end else begin
                $display("[TB] lo rst=%0b digit=%h out=%b ok", e.rst, e.digit, out_lo);
            end
            tests++;
            if (out_hi !== e.exp_hi) begin
                fails++;
                $display("FAIL hi rst=%0b digit=%h got=%b exp=%b", e.rst, e.digit, out_hi, e.exp_hi);
            end else begin
                $display("[TB] hi rst=%0b digit=%h out=%b ok", e.rst, e.digit, out_hi);
            end
        end
    end

    initial begin
        int budget;

        // Reset held two cycles with 8 on the input, then released.
        step(1'b1, 4'h8);
        step(1'b1, 4'h8);
        step(1'b0, 4'h8);

        // Decimal sweep 0..9 then 0, each held four cycles.
        for (int i = 0; i <= 10; i++) begin
            for (int h = 0; h < 4; h++) begin
                step(1'b0, (i == 10) ? 4'h0 : 4'(i));
            end
        end

        // Hex letters on consecutive cycles.
        for (int i = 10; i < 16; i++) begin
            step(1'b0, 4'(i));
        end

        // Reset asserted on the same edge the input moves from 3 to 4.
        step(1'b0, 4'h3);
        step(1'b1, 4'h4);
        step(1'b0, 4'h4);

        // All sixteen values with random hold lengths.
        for (int i = 0; i < 16; i++) begin
            int hold;
            hold = int'($urandom_range(5, 1));
            for (int h = 0; h < hold; h++) begin
                step(1'b0, 4'(i));
            end
        end

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #6;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display7.md
DISPLAY7 -- requirements
Module: display7

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = segment lit when its bit is 0 and 0 = segment lit when its bit is 1.
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port iData, input, 4 bits: the hex digit to display, 0x0-0xF.
REQ-005 The block SHALL have port oData, output, 7 bits: the segment drive, with bit 6 = g, 5 = f, 4 = e, 3 = d, 2 = c, 1 = b, 0 = a.

Function
REQ-006 oData SHALL be registered, with a latency of exactly one iClk rising edge from iData to oData and no combinational path from iData to oData.
REQ-007 With ACTIVE_LOW=1, the digit-to-oData mapping SHALL be:
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- 8 = 0000000, 9 = 0010000
REQ-008 With ACTIVE_LOW=1, digits 0xA-0xF SHALL map to:
- A = 0001000, b = 0000011, C = 1000110
- d = 0100001, E = 0000110, F = 0001110
REQ-009 With ACTIVE_LOW=0, oData SHALL be the bitwise inverse of the REQ-007/REQ-008 patterns.
REQ-010 Every 4-bit iData value SHALL produce a defined pattern, with no X or blank outputs other than in reset.
REQ-011 When iData is held constant, oData SHALL hold constant.
REQ-012 When iData changes on consecutive cycles, each value SHALL appear on oData for exactly one cycle, in order.

Reset
REQ-013 While iRst=1 at a rising edge, oData SHALL load the all-segments-off pattern: 1111111 when ACTIVE_LOW=1, 0000000 when ACTIVE_LOW=0.
REQ-014 If reset is asserted mid-operation, it SHALL override any iData update at the same edge.
REQ-015 On the first rising edge after iRst deasserts, oData SHALL load the decode of the current iData.
REQ-016 Reset SHALL have no asynchronous effect, and oData SHALL be unchanged between edges.

Structure
REQ-017 A shared package display7_pkg SHALL hold:
- the 16-entry active-low segment constant table;
- the all-off constant;
- segment bit-index constants SEG_A through SEG_G.
REQ-018 A purely combinational sub-module seg7_decode SHALL perform the 4-bit to 7-bit table lookup with polarity applied.
REQ-019 display7 SHALL contain only the output register and the reset logic around seg7_decode.

Verification
REQ-020 Reset test: assert iRst for 2 cycles with iData=0x8 -> oData=1111111 throughout reset, then 0000000 one edge after deassert.
REQ-021 Decimal sweep: iData=0,1,...,9,0, each held 4 cycles of a 10 ns clock -> oData shows the REQ-007 patterns, each lagging iData by 1 cycle, ending at 1000000.
REQ-022 Hex sweep: iData=0xA..0xF on consecutive cycles -> oData=0001000, 0000011, 1000110, 0100001, 0000110, 0001110 on the following cycles.
REQ-023 Reset mid-sweep: iRst=1 in the same cycle iData changes from 3 to 4 -> oData=1111111 at that edge, then 0011001 after release.
REQ-024 Polarity test: run REQ-021 with ACTIVE_LOW=0 -> digit 1 gives 0000110 and the reset value is 0000000.
REQ-025 Exhaustive check: all 16 values with random holds of 1-5 cycles -> oData matches a reference table delayed by 1 cycle with zero mismatches.
